// File: rtl/inflight_queue_pkg.sv
// rtl/inflight_queue_pkg.sv - shared sizing and index type for the in-flight tracking queue
package inflight_queue_pkg;
  localparam int INFLIGHT_SIZE   = 8;
  localparam int INFLIGHT_DATA_W = 32;
  localparam int INFLIGHT_PTR_W  = $clog2(INFLIGHT_SIZE);

  typedef logic [INFLIGHT_PTR_W-1:0] inflight_idx_t;
endpackage

// File: rtl/inflight_queue_flush_scan.sv
// rtl/inflight_queue_flush_scan.sv - finds the oldest flushed live entry and the contiguous kill span
module inflight_queue_flush_scan #(
  parameter int SIZE  = 8,
  parameter int PTR_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  valid,
  input  logic [SIZE-1:0]  flush_mask,
  input  logic [PTR_W-1:0] front_ptr,
  input  logic [PTR_W-1:0] back_ptr,
  input  logic [PTR_W:0]   count,
  output logic             hit,
  output logic [PTR_W-1:0] kill_idx,
  output logic [SIZE-1:0]  kill_vec,
  output logic [PTR_W:0]   kill_cnt
);
  logic [SIZE-1:0]  w_cand;
  logic [PTR_W-1:0] w_age;
  logic [PTR_W-1:0] w_span;

  // w_cand is indexed by age (0 = oldest), so the lowest set bit is the oldest flushed entry
  always_comb begin
    w_cand = '0;
    for (int a = 0; a < SIZE; a++) begin
      if ((PTR_W+1)'(a) < count)
        w_cand[a] = valid[back_ptr + PTR_W'(a)] & flush_mask[back_ptr + PTR_W'(a)];
    end
  end

  always_comb begin
    w_age = '0;
    for (int a = SIZE - 1; a >= 0; a--) begin
      if (w_cand[a]) w_age = PTR_W'(a);
    end
  end

  assign hit      = |w_cand;
  assign kill_idx = back_ptr + w_age;
  assign w_span   = front_ptr - kill_idx;

  // A hit always kills at least one entry, so a zero span means the whole ring
  assign kill_cnt = !hit ? '0 : (w_span == '0) ? (PTR_W+1)'(SIZE) : {1'b0, w_span};

  always_comb begin
    kill_vec = '0;
    for (int a = 0; a < SIZE; a++) begin
      if (hit && (PTR_W'(a) >= w_age) && ((PTR_W+1)'(a) < count))
        kill_vec[back_ptr + PTR_W'(a)] = 1'b1;
    end
  end
endmodule

// File: rtl/inflight_queue.sv
// rtl/inflight_queue.sv - circular in-order tracking queue with out-of-order completion and mask flush
module inflight_queue
  import inflight_queue_pkg::*;
#(
  parameter int SIZE   = INFLIGHT_SIZE,
  parameter int DATA_W = INFLIGHT_DATA_W,
  parameter int PTR_W  = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_valid,
  input  logic [DATA_W-1:0] alloc_data,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_idx,
  input  logic              wb_valid,
  input  logic [PTR_W-1:0]  wb_idx,
  output logic              retire_valid,
  output logic [DATA_W-1:0] retire_data,
  input  logic              retire_ready,
  input  logic              flush_valid,
  input  logic [SIZE-1:0]   flush_mask,
  output logic [PTR_W-1:0]  front_ptr,
  output logic [PTR_W-1:0]  back_ptr,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);
  logic [PTR_W-1:0]  r_front, r_back;
  logic [PTR_W:0]    r_count;
  logic [SIZE-1:0]   r_valid, r_done;
  logic [DATA_W-1:0] r_data [SIZE];

  logic              w_hit, w_flush_hit, w_alloc_fire, w_retire_fire;
  logic [PTR_W-1:0]  w_kill_idx;
  logic [SIZE-1:0]   w_kill_vec, w_valid_next, w_done_next;
  logic [PTR_W:0]    w_kill_cnt, w_killed;
  logic [PTR_W+1:0]  w_count_next;

  inflight_queue_flush_scan #(.SIZE(SIZE), .PTR_W(PTR_W)) u_scan (
    .valid      (r_valid),
    .flush_mask (flush_mask),
    .front_ptr  (r_front),
    .back_ptr   (r_back),
    .count      (r_count),
    .hit        (w_hit),
    .kill_idx   (w_kill_idx),
    .kill_vec   (w_kill_vec),
    .kill_cnt   (w_kill_cnt)
  );

  assign empty        = (r_count == '0);
  assign full         = (r_count == (PTR_W+1)'(SIZE));
  assign alloc_ready  = !full && !flush_valid;
  assign alloc_idx    = r_front;
  assign front_ptr    = r_front;
  assign back_ptr     = r_back;
  assign count        = r_count;
  assign retire_valid = r_valid[r_back] && r_done[r_back] && !empty;
  assign retire_data  = r_data[r_back];

  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_retire_fire = retire_valid && retire_ready && !(flush_valid && flush_mask[r_back]);
  assign w_flush_hit   = flush_valid && w_hit;
  assign w_killed      = w_flush_hit ? w_kill_cnt : '0;
  assign w_count_next  = {1'b0, r_count} + (PTR_W+2)'(w_alloc_fire)
                       - (PTR_W+2)'(w_retire_fire) - {1'b0, w_killed};

  // Flush is applied last so it overrides a same-cycle writeback to a killed entry
  always_comb begin
    w_valid_next = r_valid;
    w_done_next  = r_done;
    if (wb_valid && r_valid[wb_idx]) w_done_next[wb_idx] = 1'b1;
    if (w_retire_fire) begin
      w_valid_next[r_back] = 1'b0;
      w_done_next[r_back]  = 1'b0;
    end
    if (w_alloc_fire) begin
      w_valid_next[r_front] = 1'b1;
      w_done_next[r_front]  = 1'b0;
    end
    if (w_flush_hit) begin
      w_valid_next = w_valid_next & ~w_kill_vec;
      w_done_next  = w_done_next & ~w_kill_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_front <= '0;
      r_back  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_count <= w_count_next[PTR_W:0];
      if (w_retire_fire) r_back <= r_back + 1'b1;
      if (w_flush_hit) r_front <= w_kill_idx;
      else if (w_alloc_fire) r_front <= r_front + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc_fire) r_data[r_front] <= alloc_data;
  end

  // Wider count_next makes an underflow show up as a large value
  assert property (@(posedge clk) disable iff (!rstn) w_count_next <= (PTR_W+2)'(SIZE));
endmodule
